// File: rtl/div_pkg.sv
// Shared definitions for the SRT divider post-correction stage:
// op encoding, FSM state type, special-result constants and the
// bundle handed to the sign/select stage.
package div_pkg;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORRECT = 2'd1,
    SIGN    = 2'd2,
    DONE    = 2'd3
  } div_state_e;

  // Everything the sign/select stage needs, already corrected and denormalised.
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        dividend_neg;
    logic        divisor_neg;
    logic [31:0] dividend_orig;
    logic        div_by_zero;
    logic        overflow;
  } sign_in_t;

  // Overflow only matters for the signed ops (op[0] = 0).
  function automatic logic is_special(input logic [1:0] op,
                                      input logic       div_by_zero,
                                      input logic       overflow);
    return div_by_zero | (overflow & ~op[0]);
  endfunction

endpackage

// File: rtl/div_post_correct_if.sv
// Handshake bundle between the iteration controller, this stage and the
// execute stage. master drives operations in and consumes results; slave
// is the post-correction stage.
interface div_post_correct_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] q_raw;
  logic [XLEN:0]   rem_raw;
  logic [XLEN-1:0] divisor_norm;
  logic [4:0]      norm_shift;
  logic            dividend_neg;
  logic            divisor_neg;
  logic [XLEN-1:0] dividend_orig;
  logic            div_by_zero;
  logic            overflow;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, q_raw, rem_raw, divisor_norm, norm_shift,
           dividend_neg, divisor_neg, dividend_orig, div_by_zero, overflow,
           out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, q_raw, rem_raw, divisor_norm, norm_shift,
           dividend_neg, divisor_neg, dividend_orig, div_by_zero, overflow,
           out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/div_sign_fix.sv
// Combinational back end of the post-correction stage: applies the RISC-V
// sign rules to the corrected quotient/remainder, picks the one the op asks
// for, and overrides it with the divide-by-zero / overflow results.
module div_sign_fix
  import div_pkg::*;
(
  input  sign_in_t    si,
  output logic [31:0] result
);

  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Negate, select, then let the special cases win (divide-by-zero first).
  always_comb begin
    quot_s = si.quot;
    rem_s  = si.rem;
    if ((si.op == DIV) && (si.dividend_neg ^ si.divisor_neg)) begin
      quot_s = -si.quot;
    end
    if ((si.op == REM) && si.dividend_neg) begin
      rem_s = -si.rem;
    end

    result = si.op[1] ? rem_s : quot_s;

    if (si.div_by_zero) begin
      result = si.op[1] ? si.dividend_orig : DIV0_QUOT;
    end else if (si.overflow && !si.op[0]) begin
      result = si.op[1] ? 32'h0000_0000 : INT_MIN;
    end
  end

endmodule

// File: rtl/div_post_correct.sv
// Final stage of the radix-8 SRT divider. Latches the converter output,
// fixes up a negative final residual, denormalises the remainder, applies
// sign rules / special cases and holds the result until the execute stage
// takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | in_ready high, waiting for a finished division
// CORRECT | negative residual: quotient - 1, residual + divisor
// SIGN    | denormalise, sign-fix, select; result register loaded
// DONE    | out_valid high, result held until out_ready
//
// Special cases (divide by zero, signed overflow) skip CORRECT and go
// straight to SIGN, where the latched flags select the fixed result, so
// they present one cycle after accept instead of two.
module div_post_correct
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                kill,
  div_post_correct_if.slave   bus
);

  div_state_e state_q;
  div_state_e state_d;

  logic [1:0]      op_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] dnorm_q;
  logic [4:0]      shift_q;
  logic            dvd_neg_q;
  logic            dvs_neg_q;
  logic [XLEN-1:0] dvd_orig_q;
  logic            dbz_q;
  logic            ovf_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            load_result;
  sign_in_t        sf_in;
  logic [XLEN-1:0] sf_result;

  // in_ready and out_valid depend on state only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

  assign accept = (state_q == IDLE) && bus.in_valid && !kill;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and result-load strobe; kill overrides everything.
  always_comb begin
    state_d     = state_q;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = is_special(bus.op, bus.div_by_zero, bus.overflow) ? SIGN : CORRECT;
        end
      end
      CORRECT: begin
        state_d = SIGN;
      end
      SIGN: begin
        state_d     = DONE;
        load_result = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (kill) begin
      state_d     = IDLE;
      load_result = 1'b0;
    end
  end

  // Operand latch on accept, in-place residual correction in CORRECT,
  // result register loaded in SIGN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dnorm_q    <= '0;
      shift_q    <= '0;
      dvd_neg_q  <= 1'b0;
      dvs_neg_q  <= 1'b0;
      dvd_orig_q <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        op_q       <= bus.op;
        quot_q     <= bus.q_raw;
        rem_q      <= bus.rem_raw;
        dnorm_q    <= bus.divisor_norm;
        shift_q    <= bus.norm_shift;
        dvd_neg_q  <= bus.dividend_neg;
        dvs_neg_q  <= bus.divisor_neg;
        dvd_orig_q <= bus.dividend_orig;
        dbz_q      <= bus.div_by_zero;
        ovf_q      <= bus.overflow;
      end else if ((state_q == CORRECT) && !kill && rem_q[XLEN]) begin
        // q_raw = 0 wraps to all ones here; legal inputs never reach it.
        quot_q <= quot_q - 1'b1;
        rem_q  <= rem_q + {1'b0, dnorm_q};
      end
      if (load_result) begin
        result_q <= sf_result;
      end
    end
  end

  // Denormalise the corrected residual and bundle the latched operands.
  always_comb begin
    sf_in               = '0;
    sf_in.op            = op_q;
    sf_in.quot          = quot_q;
    sf_in.rem           = rem_q[XLEN-1:0] >> shift_q;
    sf_in.dividend_neg  = dvd_neg_q;
    sf_in.divisor_neg   = dvs_neg_q;
    sf_in.dividend_orig = dvd_orig_q;
    sf_in.div_by_zero   = dbz_q;
    sf_in.overflow      = ovf_q;
  end

  div_sign_fix u_sign_fix (
    .si     (sf_in),
    .result (sf_result)
  );

endmodule

// File: tb/tb_div_post_correct.sv
// Bench for div_post_correct. Operations are described by their true
// operands (rs1, rs2); the bench builds the converter-side view (quotient,
// residual, normalisation) from them and predicts rd with plain RISC-V
// division arithmetic.
module tb_div_post_correct;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic kill;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] last_result;

  div_post_correct_if #(.XLEN(32)) bus ();

  div_post_correct #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kill  (kill),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics.
  function automatic logic [31:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
      DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Drive the converter-side inputs for rs1=a, rs2=b. use_neg presents the
  // result as quotient+1 with a negative residual; shift_req < 0 picks a
  // random legal normalisation.
  task automatic setup_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit use_neg, input int shift_req, input bit force_ovf);
    bit          sgn;
    logic [31:0] ma, mb, q, r, dn, rn;
    int          clz, s;
    sgn = ~op[0];
    bus.op            = op;
    bus.dividend_neg  = sgn & a[31];
    bus.divisor_neg   = sgn & b[31];
    ma = bus.dividend_neg ? -a : a;
    mb = bus.divisor_neg ? -b : b;
    bus.dividend_orig = a;
    bus.div_by_zero   = (b == 0);
    bus.overflow      = force_ovf | (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (mb == 0) begin
      bus.q_raw        = $urandom;
      bus.rem_raw      = '0;
      bus.divisor_norm = '0;
      bus.norm_shift   = '0;
    end else begin
      clz = 0;
      for (int i = 31; i >= 0 && !mb[i]; i--) clz++;
      if (shift_req < 0) s = $urandom_range(clz, 0);
      else s = (shift_req > clz) ? clz : shift_req;
      q  = ma / mb;
      r  = ma % mb;
      dn = mb << s;
      rn = r << s;
      bus.norm_shift   = s[4:0];
      bus.divisor_norm = dn;
      if (use_neg && q != 32'hFFFF_FFFF) begin
        bus.q_raw   = q + 1;
        bus.rem_raw = {1'b0, rn} - {1'b0, dn};
      end else begin
        bus.q_raw   = q;
        bus.rem_raw = {1'b0, rn};
      end
    end
  endtask

  // One full transaction: accept, latency, result, backpressure, release.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use_neg, input int shift_req, input bit force_ovf,
                       input int hold, input string tag);
    logic [31:0] exp;
    bit          special;
    int          cyc;
    @(negedge clk);
    setup_op(op, a, b, use_neg, shift_req, force_ovf);
    exp     = ref_result(op, a, b);
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    chk({tag, " in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, special ? 32'd1 : 32'd2);
    chk({tag, " result"}, bus.result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold result"}, bus.result, exp);
      chk({tag, " hold valid/ready"}, {30'b0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " release valid/ready"}, {30'b0, bus.out_valid, bus.in_ready}, 32'd1);
    last_result = exp;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel;
    bit          seen_valid;

    rst_n            = 1'b0;
    kill             = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.op           = '0;
    bus.q_raw        = '0;
    bus.rem_raw      = '0;
    bus.divisor_norm = '0;
    bus.norm_shift   = '0;
    bus.dividend_neg = 1'b0;
    bus.divisor_neg  = 1'b0;
    bus.dividend_orig= '0;
    bus.div_by_zero  = 1'b0;
    bus.overflow     = 1'b0;
    last_result      = '0;

    repeat (3) @(negedge clk);
    chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset result", bus.result, 32'd0);
    rst_n = 1'b1;

    // Worked examples.
    do_op(DIVU, 32'd100, 32'd7, 1'b1, 0, 1'b0, 0, "divu_100_7");
    do_op(REMU, 32'd100, 32'd7, 1'b1, 0, 1'b0, 0, "remu_100_7");
    do_op(DIV, -32'sd100, 32'd7, 1'b1, 0, 1'b0, 0, "div_m100_7");
    do_op(REM, -32'sd100, 32'd7, 1'b1, 0, 1'b0, 0, "rem_m100_7");
    do_op(REMU, 32'd100, 32'd7, 1'b0, 29, 1'b0, 0, "remu_norm29");
    do_op(DIVU, 32'd100, 32'd7, 1'b0, 29, 1'b0, 0, "divu_norm29");
    do_op(DIV, 32'd100, -32'sd7, 1'b1, 3, 1'b0, 0, "div_100_m7");
    do_op(REM, -32'sd100, -32'sd7, 1'b0, 5, 1'b0, 0, "rem_m100_m7");

    // Special cases.
    do_op(DIVU, 32'd5, 32'd0, 1'b0, 0, 1'b0, 0, "divu_by_zero");
    do_op(DIV, 32'hF000_0000, 32'd0, 1'b0, 0, 1'b0, 0, "div_by_zero");
    do_op(REM, 32'h1234_5678, 32'd0, 1'b0, 0, 1'b0, 0, "rem_by_zero");
    do_op(REMU, 32'h8765_4321, 32'd0, 1'b0, 0, 1'b0, 0, "remu_by_zero");
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0, "div_overflow");
    do_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 0, "rem_overflow");
    do_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b1, 0, "divu_ovf_ignored");
    do_op(REMU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b1, 0, "remu_ovf_ignored");
    do_op(DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 1'b0, 0, "divu_max_by_1");

    // Backpressure.
    do_op(DIVU, 32'd1000, 32'd3, 1'b1, -1, 1'b0, 5, "backpressure");
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 5, "bp_special");

    // Random operations.
    repeat (300) begin
      op  = 2'($urandom_range(3, 0));
      sel = $urandom_range(9, 0);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2, 3: b = 32'($urandom_range(15, 1));
        4: b = 32'($urandom) >> $urandom_range(31, 0);
        default: b = $urandom;
      endcase
      a = ($urandom_range(9, 0) == 0) ? 32'h8000_0000 : 32'($urandom);
      do_op(op, a, b, 1'($urandom_range(1, 0)), -1, 1'b0, $urandom_range(2, 0), "random");
    end

    // kill during CORRECT: back to IDLE, out_valid never rises, result kept.
    @(negedge clk);
    setup_op(DIVU, 32'd77, 32'd5, 1'b1, 0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_correct in_ready", {31'b0, bus.in_ready}, 32'd1);
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_valid |= bus.out_valid;
    end
    chk("kill_correct no valid", {31'b0, seen_valid}, 32'd0);
    chk("kill_correct result kept", bus.result, last_result);

    // kill with simultaneous in_valid: nothing accepted.
    setup_op(DIV, 32'd9, 32'd2, 1'b0, 0, 1'b0);
    bus.in_valid = 1'b1;
    kill = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    kill = 1'b0;
    chk("kill_accept in_ready", {31'b0, bus.in_ready}, 32'd1);
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_valid |= bus.out_valid;
    end
    chk("kill_accept no valid", {31'b0, seen_valid}, 32'd0);

    // kill in DONE together with out_ready: valid drops, result held.
    setup_op(REMU, 32'd50, 32'd6, 1'b1, 1, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("kill_done valid before", {31'b0, bus.out_valid}, 32'd1);
    kill = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    bus.out_ready = 1'b0;
    chk("kill_done valid/ready", {30'b0, bus.out_valid, bus.in_ready}, 32'd1);
    chk("kill_done result held", bus.result, 32'd2);

    // Reset pulsed during SIGN: outputs clear immediately.
    setup_op(DIVU, 32'd1000, 32'd7, 1'b1, 0, 1'b0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_sign out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_sign result", bus.result, 32'd0);
    chk("rst_sign in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(DIV, -32'sd1000, 32'd7, 1'b1, -1, 1'b0, 1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
